apb_master_asynch: RTL and testbench

- Source-clock-domain half of the APB clock-domain crossing.
- Accepts an APB transfer from a local APB master and forwards it as a bundled-data, four-phase req/ack transaction to the destination half: req up -> ack up -> req down -> ack down.
- Returns the read data and error status, then completes the local transfer with a PREADY_o pulse.
- Pairs with the destination-side APB CDC block, which drives the real APB bus in the destination clock domain.

---
 rtl/apb_master_asynch.sv | 119 +++++++++++
 tb/tb_apb_master_asynch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_asynch.sv
// Source-domain half of an APB clock-domain crossing: one local APB transfer becomes one
// four-phase bundled-data req/ack handshake. Optional macro: APB_ASYNCH_EARLY_RESP_EN.
`timescale 1ns/1ps
module apb_master_asynch #(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR_i,
  input  logic [APB_DATA_WIDTH-1:0] PWDATA_i,
  input  logic                      PWRITE_i,
  input  logic                      PSEL_i,
  input  logic                      PENABLE_i,
  output logic [APB_DATA_WIDTH-1:0] PRDATA_o,
  output logic                      PREADY_o,
  output logic                      PSLVERR_o,
  output logic                      asynch_req_o,
  input  logic                      asynch_ack_i,
  output logic [APB_ADDR_WIDTH-1:0] async_PADDR_o,
  output logic [APB_DATA_WIDTH-1:0] async_PWDATA_o,
  output logic                      async_PWRITE_o,
  output logic                      async_PSEL_o,
  input  logic [APB_DATA_WIDTH-1:0] async_PRDATA_i,
  input  logic                      async_PSLVERR_i
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQ_UP     = 3'd1,
    ACK_DOWN   = 3'd2,
    RESP       = 3'd3,
    EARLY_RESP = 3'd4
  } state_e;

  state_e                    state_q;
  logic                      ack_sync0_q;
  logic                      ack_sync_q;
  logic                      req_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      pwrite_q;
  logic                      psel_q;
  logic [APB_DATA_WIDTH-1:0] prdata_q;
  logic                      pslverr_q;

  // Payload loads on the same edge req rises, so it is settled before the far side sees req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ack_sync0_q <= 1'b0;
      ack_sync_q  <= 1'b0;
      req_q       <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
    end else begin
      ack_sync0_q <= asynch_ack_i;
      ack_sync_q  <= ack_sync0_q;
      case (state_q)
        IDLE: begin
          if (PSEL_i && PENABLE_i) begin
            paddr_q  <= PADDR_i;
            pwdata_q <= PWDATA_i;
            pwrite_q <= PWRITE_i;
            psel_q   <= PSEL_i;
            req_q    <= 1'b1;
            state_q  <= REQ_UP;
          end
        end
        REQ_UP: begin
          // Response bus is only trusted once ack has crossed the synchronizer.
          if (ack_sync_q) begin
            prdata_q  <= async_PRDATA_i;
            pslverr_q <= async_PSLVERR_i;
            req_q     <= 1'b0;
`ifdef APB_ASYNCH_EARLY_RESP_EN
            state_q   <= EARLY_RESP;
`else
            state_q   <= ACK_DOWN;
`endif
          end
        end
        ACK_DOWN: begin
          if (!ack_sync_q) begin
`ifdef APB_ASYNCH_EARLY_RESP_EN
            state_q <= IDLE;
`else
            state_q <= RESP;
`endif
          end
        end
        RESP: state_q <= IDLE;
`ifdef APB_ASYNCH_EARLY_RESP_EN
        EARLY_RESP: state_q <= ACK_DOWN;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef APB_ASYNCH_EARLY_RESP_EN
  assign PREADY_o = (state_q == EARLY_RESP);
`else
  assign PREADY_o = (state_q == RESP);
`endif

  assign asynch_req_o   = req_q;
  assign async_PADDR_o  = paddr_q;
  assign async_PWDATA_o = pwdata_q;
  assign async_PWRITE_o = pwrite_q;
  assign async_PSEL_o   = psel_q;
  assign PRDATA_o       = prdata_q;
  assign PSLVERR_o      = pslverr_q;

endmodule

// File: tb/tb_apb_master_asynch.sv
// Bench for apb_master_asynch: directed APB transfers against a four-phase destination model,
// with expected payloads and responses queued by the driver and checked by a monitor.
`timescale 1ns/1ps
module tb_apb_master_asynch;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PW = AW + DW + 2;
  localparam int RW = DW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] PADDR_i = '0;
  logic [DW-1:0] PWDATA_i = '0;
  logic          PWRITE_i = 1'b0;
  logic          PSEL_i = 1'b0;
  logic          PENABLE_i = 1'b0;
  logic [DW-1:0] PRDATA_o;
  logic          PREADY_o;
  logic          PSLVERR_o;
  logic          asynch_req_o;
  logic          asynch_ack_i = 1'b0;
  logic [AW-1:0] async_PADDR_o;
  logic [DW-1:0] async_PWDATA_o;
  logic          async_PWRITE_o;
  logic          async_PSEL_o;
  logic [DW-1:0] async_PRDATA_i = '0;
  logic          async_PSLVERR_i = 1'b0;

  apb_master_asynch #(.APB_DATA_WIDTH(DW), .APB_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .PADDR_i(PADDR_i), .PWDATA_i(PWDATA_i), .PWRITE_i(PWRITE_i),
    .PSEL_i(PSEL_i), .PENABLE_i(PENABLE_i),
    .PRDATA_o(PRDATA_o), .PREADY_o(PREADY_o), .PSLVERR_o(PSLVERR_o),
    .asynch_req_o(asynch_req_o), .asynch_ack_i(asynch_ack_i),
    .async_PADDR_o(async_PADDR_o), .async_PWDATA_o(async_PWDATA_o),
    .async_PWRITE_o(async_PWRITE_o), .async_PSEL_o(async_PSEL_o),
    .async_PRDATA_i(async_PRDATA_i), .async_PSLVERR_i(async_PSLVERR_i)
  );

  int checks = 0;
  int failures = 0;
  int pready_cnt = 0;
  int xfer_cnt = 0;

  logic [PW-1:0] exp_req_q[$];
  logic [RW-1:0] exp_rsp_q[$];
  logic [PW-1:0] cur_pl = '0;
  logic          req_prev = 1'b0;
  logic          pready_prev = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Destination model: ack after ack_delay cycles of req, drop ack ack_hold cycles after req falls.
  int            ack_delay = 0;
  int            ack_hold = 0;
  logic [DW-1:0] bfm_rdata = '0;
  logic          bfm_err = 1'b0;
  int            bst = 0;
  int            bcnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bst = 0;
        asynch_ack_i = 1'b0;
      end else begin
        case (bst)
          0: if (asynch_req_o) begin bcnt = 0; bst = 1; end
          1: if (!asynch_req_o) bst = 0;
             else if (bcnt == ack_delay) begin
               async_PRDATA_i  = bfm_rdata;
               async_PSLVERR_i = bfm_err;
               asynch_ack_i    = 1'b1;
               bst = 2;
             end else bcnt++;
          2: if (!asynch_req_o) begin bcnt = 0; bst = 3; end
          default: if (bcnt == ack_hold) begin
               asynch_ack_i    = 1'b0;
               async_PRDATA_i  = '0;
               async_PSLVERR_i = 1'b0;
               bst = 0;
             end else bcnt++;
        endcase
      end
    end
  end

  // Monitor: payload vs model every cycle, response popped on each PREADY pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (asynch_req_o && !req_prev) begin
          check("ack_low_at_req_rise", 128'(asynch_ack_i), 128'(1'b0));
          if (exp_req_q.size() == 0) check("unexpected_req", 128'(1'b1), 128'(1'b0));
          else cur_pl = exp_req_q.pop_front();
        end
        check("payload", 128'({async_PADDR_o, async_PWDATA_o, async_PWRITE_o, async_PSEL_o}),
              128'(cur_pl));
        if (PREADY_o) begin
          pready_cnt++;
          check("pready_single_cycle", 128'(pready_prev), 128'(1'b0));
          check("req_low_at_pready", 128'(asynch_req_o), 128'(1'b0));
`ifdef APB_ASYNCH_EARLY_RESP_EN
          check("ack_high_at_early_pready", 128'(asynch_ack_i), 128'(1'b1));
`else
          check("ack_low_at_pready", 128'(asynch_ack_i), 128'(1'b0));
`endif
          if (exp_rsp_q.size() == 0) check("unexpected_pready", 128'(1'b1), 128'(1'b0));
          else check("response", 128'({PRDATA_o, PSLVERR_o}), 128'(exp_rsp_q.pop_front()));
        end
        req_prev    = asynch_req_o;
        pready_prev = PREADY_o;
      end else begin
        req_prev    = 1'b0;
        pready_prev = 1'b0;
      end
    end
  end

  function automatic int lat(input int d, input int h);
`ifdef APB_ASYNCH_EARLY_RESP_EN
    lat = 4 + d + (h * 0);
`else
    lat = 8 + d + h;
`endif
  endfunction

  // Driver: one APB transfer; exp_lat < 0 skips the latency check.
  task automatic xfer(input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic wr,
                      input logic [DW-1:0] rdata, input logic err, input int d, input int h,
                      input bit jitter, input int exp_lat);
    int  cyc;
    bit  seen;
    ack_delay = d;
    ack_hold  = h;
    bfm_rdata = rdata;
    bfm_err   = err;
    exp_req_q.push_back({addr, wdata, wr, 1'b1});
    exp_rsp_q.push_back({rdata, err});
    xfer_cnt++;
    @(posedge clk); #1;
    PADDR_i = addr; PWDATA_i = wdata; PWRITE_i = wr; PSEL_i = 1'b1; PENABLE_i = 1'b0;
    @(posedge clk); #1;
    PENABLE_i = 1'b1;
    @(posedge clk);
    cyc  = 0;
    seen = 0;
    while (cyc < 400) begin
      @(negedge clk);
      if (PREADY_o) begin seen = 1; break; end
      @(posedge clk);
      cyc++;
      if (jitter) begin #1; PADDR_i = addr ^ AW'(cyc * 32'h0101_0101); PWDATA_i = ~PWDATA_i; end
    end
    if (!seen) check("pready_timeout", 128'(1'b0), 128'(1'b1));
    else if (exp_lat >= 0) check("latency", 128'(cyc), 128'(exp_lat));
    @(posedge clk); #1;
    PSEL_i = 1'b0; PENABLE_i = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req"}, 128'(asynch_req_o), 128'(1'b0));
    check({tag, "_pready"}, 128'(PREADY_o), 128'(1'b0));
    check({tag, "_prdata_pslverr"}, 128'({PRDATA_o, PSLVERR_o}), 128'(0));
    check({tag, "_async_payload"},
          128'({async_PADDR_o, async_PWDATA_o, async_PWRITE_o, async_PSEL_o}), 128'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    xfer(32'h1A2B_0004, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 3, 0, 1'b0, lat(3, 0));
    xfer(32'h0000_0010, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b1, 1, 2, 1'b0, lat(1, 2));
    xfer(32'h0000_0F00, 32'h1357_9BDF, 1'b1, 32'h0, 1'b0, 4, 1, 1'b1, lat(4, 1));
    xfer(32'h0000_0020, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b1, 50, 20, 1'b0, lat(50, 20));

    // Reset while waiting in REQ_UP for a slow ack.
    ack_delay = 10; ack_hold = 0; bfm_rdata = 32'h7777_7777; bfm_err = 1'b0;
    exp_req_q.push_back({32'h0000_0055, 32'h0000_0066, 1'b1, 1'b1});
    @(posedge clk); #1;
    PADDR_i = 32'h55; PWDATA_i = 32'h66; PWRITE_i = 1'b1; PSEL_i = 1'b1; PENABLE_i = 1'b0;
    @(posedge clk); #1 PENABLE_i = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("req_before_reset", 128'(asynch_req_o), 128'(1'b1));
    rst_n = 1'b0;
    cur_pl = '0;
    #1 check_outputs_zero("midreset");
    PSEL_i = 1'b0; PENABLE_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    xfer(32'h0000_0100, 32'h0, 1'b0, 32'hA5A5_0001, 1'b0, 0, 0, 1'b0, lat(0, 0));
    // Back-to-back: the second access may be stalled behind the first ack fall.
    xfer(32'h0000_0200, 32'hFFFF_0000, 1'b1, 32'h0, 1'b1, 2, 10, 1'b0, lat(2, 10));
    xfer(32'h0000_0300, 32'h0, 1'b0, 32'h5A5A_0003, 1'b0, 1, 0, 1'b0, -1);

    repeat (20) @(posedge clk);
    #1;
    check("pready_count", 128'(pready_cnt), 128'(xfer_cnt));
    check("req_queue_empty", 128'(exp_req_q.size()), 128'(0));
    check("rsp_queue_empty", 128'(exp_rsp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
